store_queue: RTL and testbench
==============================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, store data width (32 or 64); DEPTH, default 4, entries (power of 2, >=2); DM_START/DM_END, default 0x0000_0000/0x0000_2FFF, data memory window; T0_START/T0_END, default 0x0000_7F00/0x0000_7F0B, timer-0 window; T1_START/T1_END, default 0x0000_7F10/0x0000_7F1B, timer-1 window; COUNT_OFF, default 8, COUNT register offset inside each timer window.
REQ-002 Ports SHALL be: clk in 1 clock; reset_n in 1 reset; req_valid in 1 store request; req_ready out 1 queue can accept; req_size in 2 log2 bytes (0=byte,1=half,2=word,3=dword); req_addr in 32 byte address; req_wdata in DATA_W right-aligned store data; mem_valid out 1 head entry valid; mem_ready in 1 memory accepts head; mem_addr out 32 address aligned to DATA_W/8; mem_byteen out DATA_W/8 lane enables; mem_wdata out DATA_W lane-shifted data; exc_valid out 1 exception pulse; exc_code out 2 cause; exc_badvaddr out 32 faulting address; count out $clog2(DEPTH)+1 occupancy; empty out 1.
REQ-003 The clock SHALL be the single clk; reset SHALL be asynchronous, active-low on reset_n.

Function
REQ-004 A request SHALL be accepted on a rising clk edge when req_valid && req_ready.
REQ-005 req_ready SHALL equal !full (count==DEPTH means full); no same-cycle bypass when full.
REQ-006 Each accepted request SHALL be checked combinationally; exc_code priority: 2'b01 misaligned > 2'b10 out-of-range > 2'b11 timer-protect.
REQ-007 Misaligned: req_addr mod 2^req_size != 0, or 2^req_size > DATA_W/8.
REQ-008 Out-of-range: first byte and last byte (req_addr + 2^req_size - 1) not both inside one of DM, T0 or T1 windows (inclusive bounds).
REQ-009 Timer-protect: access lies in T0 or T1 and either req_size < 2, or the accessed aligned word equals window start + COUNT_OFF.
REQ-010 A faulting request SHALL NOT be enqueued; exc_valid SHALL pulse high for exactly one cycle, the cycle after acceptance, with exc_code and exc_badvaddr=req_addr registered.
REQ-011 A clean request SHALL be written to the tail entry holding mem_addr = req_addr with low $clog2(DATA_W/8) bits cleared, mem_byteen = (2^(2^req_size) - 1) << lane offset, mem_wdata = req_wdata shifted left by 8 x lane offset (unused lanes zero).
REQ-012 mem_valid SHALL equal !empty; mem_addr/mem_byteen/mem_wdata SHALL reflect the head entry; head pops when mem_valid && mem_ready.
REQ-013 Minimum latency accept -> mem_valid SHALL be one cycle; entries SHALL drain in acceptance order.
REQ-014 Simultaneous push and pop SHALL leave count unchanged; push when full is impossible; pop when empty ignored.
REQ-015 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-016 Outputs while empty: mem_byteen=0, mem_wdata=0, mem_addr=0.

Reset
REQ-017 Asserting reset_n low SHALL immediately clear pointers and count, discard all entries (including mid-drain), and drive exc_valid=0, exc_code=0, exc_badvaddr=0, empty=1, mem_valid=0, req_ready=0 while held low.
REQ-018 req_ready SHALL rise on the first clk edge after reset_n deasserts.

Structure
REQ-019 Size encodings, exc_code values and default window constants SHALL live in the shared macro/package file used by the CPU.
REQ-020 Address/size checking and lane formatting SHALL be one combinational sub-module, store_check; queue storage and pointers stay in store_queue.

Verification (DATA_W=32, DEPTH=4, defaults)
REQ-021 Word store 0x0000_1004, data 0xDEADBEEF, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1004, byteen=4'b1111, wdata=0xDEADBEEF; drained, empty=1.
REQ-022 Byte store 0x0000_0003, data 0x000000AB -> byteen=4'b1000, wdata=0xAB000000; half store 0x0000_0002, data 0x1234 -> byteen=4'b1100, wdata=0x12340000.
REQ-023 Half store 0x0000_0001 -> exc_valid one-cycle pulse, exc_code=01, badvaddr=0x0000_0001, count unchanged; word store 0x0000_3000 -> code 10.
REQ-024 Word store 0x7F08 -> code 11; byte store 0x7F04 -> code 11; word store 0x7F14 -> enqueued, byteen=4'b1111.
REQ-025 mem_ready=0, five back-to-back clean stores -> req_ready low after 4th, count=4; then mem_ready=1 with continuous push -> count holds, order preserved, pointers wrap.
REQ-026 reset_n low with count=3 mid-drain -> immediately count=0, mem_valid=0, exc_valid=0; after release, first store drains normally.

Source files
------------

// File: rtl/store_queue_pkg.sv
// Shared encodings and default address map for the store path.
// Size codes, exception causes and window bounds are common to the CPU and the queue.
package store_queue_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_RANGE    = 2'd2,
        EXC_TPROT    = 2'd3
    } exc_e;

    localparam logic [31:0] DM_START_DEF  = 32'h0000_0000;
    localparam logic [31:0] DM_END_DEF    = 32'h0000_2FFF;
    localparam logic [31:0] T0_START_DEF  = 32'h0000_7F00;
    localparam logic [31:0] T0_END_DEF    = 32'h0000_7F0B;
    localparam logic [31:0] T1_START_DEF  = 32'h0000_7F10;
    localparam logic [31:0] T1_END_DEF    = 32'h0000_7F1B;
    localparam int          COUNT_OFF_DEF = 8;

    // Addresses are carried at 33 bits so a last byte that wraps past 4 GiB never aliases low memory.
    function automatic logic in_window(input logic [32:0] a, input logic [31:0] lo, input logic [31:0] hi);
        return (a >= {1'b0, lo}) && (a <= {1'b0, hi});
    endfunction

endpackage

// File: rtl/store_check.sv
// Combinational store validation and byte-lane formatting.
// Produces the exception cause and the bus-aligned address/byteen/data for one request.
module store_check
    import store_queue_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] DM_START  = DM_START_DEF,
    parameter logic [31:0] DM_END    = DM_END_DEF,
    parameter logic [31:0] T0_START  = T0_START_DEF,
    parameter logic [31:0] T0_END    = T0_END_DEF,
    parameter logic [31:0] T1_START  = T1_START_DEF,
    parameter logic [31:0] T1_END    = T1_END_DEF,
    parameter int          COUNT_OFF = COUNT_OFF_DEF
) (
    input  logic [1:0]          size_i,
    input  logic [31:0]         addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                fault_o,
    output logic [1:0]          code_o,
    output logic [31:0]         addr_o,
    output logic [DATA_W/8-1:0] byteen_o,
    output logic [DATA_W-1:0]   wdata_o
);

    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam logic [31:0] T0_CNT = T0_START + 32'(COUNT_OFF);
    localparam logic [31:0] T1_CNT = T1_START + 32'(COUNT_OFF);

    logic [3:0]        nbytes;
    logic [31:0]       size_mask;
    logic [32:0]       first_a;
    logic [32:0]       last_a;
    logic [31:0]       word_addr;
    logic              misalign;
    logic              hit_dm;
    logic              hit_t0;
    logic              hit_t1;
    logic              out_of_range;
    logic              timer_prot;
    logic [LW-1:0]     lane_off;
    logic [NB-1:0]     lane_en;
    logic [DATA_W-1:0] data_masked;

    assign nbytes    = 4'd1 << size_i;
    assign size_mask = {28'd0, nbytes} - 32'd1;
    assign first_a   = {1'b0, addr_i};
    assign last_a    = first_a + {29'd0, nbytes} - 33'd1;
    assign word_addr = {addr_i[31:2], 2'b00};

    assign misalign = (|(addr_i & size_mask)) || ({28'd0, nbytes} > 32'(NB));

    assign hit_dm = in_window(first_a, DM_START, DM_END) && in_window(last_a, DM_START, DM_END);
    assign hit_t0 = in_window(first_a, T0_START, T0_END) && in_window(last_a, T0_START, T0_END);
    assign hit_t1 = in_window(first_a, T1_START, T1_END) && in_window(last_a, T1_START, T1_END);
    assign out_of_range = !(hit_dm || hit_t0 || hit_t1);

    // Timer registers only take full-word writes, and COUNT is never software-writable.
    assign timer_prot = (hit_t0 && ((size_i < SZ_WORD) || (word_addr == T0_CNT))) ||
                        (hit_t1 && ((size_i < SZ_WORD) || (word_addr == T1_CNT)));

    always_comb begin
        code_o = EXC_NONE;
        if (misalign)          code_o = EXC_MISALIGN;
        else if (out_of_range) code_o = EXC_RANGE;
        else if (timer_prot)   code_o = EXC_TPROT;
    end
    assign fault_o = (code_o != EXC_NONE);

    assign lane_off = addr_i[LW-1:0];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_en[gi]            = (32'(gi) < 32'(nbytes));
            assign data_masked[8*gi +: 8] = lane_en[gi] ? wdata_i[8*gi +: 8] : 8'd0;
        end
    endgenerate

    assign addr_o   = {addr_i[31:LW], LW'(0)};
    assign byteen_o = lane_en << lane_off;
    assign wdata_o  = data_masked << {lane_off, 3'b000};

endmodule

// File: rtl/store_queue.sv
// In-order store queue: validates each store, reports faults, buffers clean
// stores as bus-formatted entries and presents the oldest to memory.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] DM_START  = DM_START_DEF,
    parameter logic [31:0] DM_END    = DM_END_DEF,
    parameter logic [31:0] T0_START  = T0_START_DEF,
    parameter logic [31:0] T0_END    = T0_END_DEF,
    parameter logic [31:0] T1_START  = T1_START_DEF,
    parameter logic [31:0] T1_END    = T1_END_DEF,
    parameter int          COUNT_OFF = COUNT_OFF_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_size,
    input  logic [31:0]                 req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [31:0]                 mem_addr,
    output logic [DATA_W/8-1:0]         mem_byteen,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        exc_valid,
    output logic [1:0]                  exc_code,
    output logic [31:0]                 exc_badvaddr,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);

    localparam int NB = DATA_W / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       addr_mem [DEPTH];
    logic [NB-1:0]     be_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;
    logic          exc_valid_q;
    logic [1:0]    exc_code_q;
    logic [31:0]   exc_badvaddr_q;

    logic              chk_fault;
    logic [1:0]        chk_code;
    logic [31:0]       chk_addr;
    logic [NB-1:0]     chk_byteen;
    logic [DATA_W-1:0] chk_wdata;
    logic              accept;
    logic              push;
    logic              pop;

    store_check #(
        .DATA_W   (DATA_W),
        .DM_START (DM_START),
        .DM_END   (DM_END),
        .T0_START (T0_START),
        .T0_END   (T0_END),
        .T1_START (T1_START),
        .T1_END   (T1_END),
        .COUNT_OFF(COUNT_OFF)
    ) u_check (
        .size_i  (req_size),
        .addr_i  (req_addr),
        .wdata_i (req_wdata),
        .fault_o (chk_fault),
        .code_o  (chk_code),
        .addr_o  (chk_addr),
        .byteen_o(chk_byteen),
        .wdata_o (chk_wdata)
    );

    // ready_q holds req_ready low during reset and through the release edge.
    assign req_ready = ready_q && (count_q != CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_valid = !empty;
    assign accept    = req_valid && req_ready;
    assign push      = accept && !chk_fault;
    assign pop       = mem_valid && mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            ready_q        <= 1'b0;
            exc_valid_q    <= 1'b0;
            exc_code_q     <= '0;
            exc_badvaddr_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ready_q     <= 1'b1;
            exc_valid_q <= accept && chk_fault;
            if (accept && chk_fault) begin
                exc_code_q     <= chk_code;
                exc_badvaddr_q <= req_addr;
            end
        end
    end

    // Entry storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= chk_addr;
            be_mem[tail_q]   <= chk_byteen;
            data_mem[tail_q] <= chk_wdata;
        end
    end

    assign mem_addr     = mem_valid ? addr_mem[head_q] : '0;
    assign mem_byteen   = mem_valid ? be_mem[head_q]   : '0;
    assign mem_wdata    = mem_valid ? data_mem[head_q] : '0;
    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_badvaddr = exc_badvaddr_q;
    assign count        = count_q;

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue at DATA_W=32, DEPTH=4 with the default address map.
module tb_store_queue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        exc_valid;
    logic [1:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic [2:0]  count;
    logic        empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_queue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_byteen  (mem_byteen),
        .mem_wdata   (mem_wdata),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .exc_badvaddr(exc_badvaddr),
        .count       (count),
        .empty       (empty)
    );

    // Presents one request for a single edge; returns 1 ns after that edge.
    task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        $display("store size=%0d addr=%h data=%h count=%0d exc=%b code=%0d", sz, a, d, count, exc_valid, exc_code);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count !== 3'd0)   begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b want 0", mem_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
        checks++; if (exc_valid !== 1'b0 || exc_code !== 2'd0 || exc_badvaddr !== 32'd0)
            begin errors++; $display("FAIL rst_exc got %b/%0d/%h want 0/0/0", exc_valid, exc_code, exc_badvaddr); end
        @(negedge clk); reset_n = 1'b1; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", req_ready); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b want 1", req_ready); end
        $display("reset released ready=%b", req_ready);
    endtask

    task automatic test_word();
        mem_ready = 1'b1;
        send(2'd2, 32'h0000_1004, 32'hDEAD_BEEF);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL word_valid got %b want 1", mem_valid); end
        checks++; if (mem_addr !== 32'h0000_1004) begin errors++; $display("FAIL word_addr got %h want 00001004", mem_addr); end
        checks++; if (mem_byteen !== 4'b1111) begin errors++; $display("FAIL word_byteen got %b want 1111", mem_byteen); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_wdata got %h want deadbeef", mem_wdata); end
        @(posedge clk); #1;
        checks++; if (empty !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL word_drain got empty=%b valid=%b want 1/0", empty, mem_valid); end
        checks++; if (mem_addr !== 32'd0 || mem_byteen !== 4'd0 || mem_wdata !== 32'd0)
            begin errors++; $display("FAIL empty_outputs got %h/%b/%h want 0/0/0", mem_addr, mem_byteen, mem_wdata); end
    endtask

    task automatic test_lanes();
        mem_ready = 1'b0;
        send(2'd0, 32'h0000_0003, 32'h0000_00AB);
        checks++; if (mem_byteen !== 4'b1000) begin errors++; $display("FAIL byte_byteen got %b want 1000", mem_byteen); end
        checks++; if (mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL byte_wdata got %h want ab000000", mem_wdata); end
        checks++; if (mem_addr !== 32'h0000_0000) begin errors++; $display("FAIL byte_addr got %h want 00000000", mem_addr); end
        send(2'd1, 32'h0000_0002, 32'h0000_1234);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL lanes_count got %0d want 2", count); end
        checks++; if (mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL head_kept got %h want ab000000", mem_wdata); end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_byteen !== 4'b1100) begin errors++; $display("FAIL half_byteen got %b want 1100", mem_byteen); end
        checks++; if (mem_wdata !== 32'h1234_0000) begin errors++; $display("FAIL half_wdata got %h want 12340000", mem_wdata); end
        @(posedge clk); #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lanes_drain got %b want 1", empty); end
    endtask

    task automatic test_exceptions();
        logic [1:0]  sz_t   [4] = '{2'd1, 2'd2, 2'd2, 2'd0};
        logic [31:0] addr_t [4] = '{32'h0000_0001, 32'h0000_3000, 32'h0000_7F08, 32'h0000_7F04};
        logic [1:0]  code_t [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(sz_t[i], addr_t[i], 32'h1111_2222);
            checks++; if (exc_valid !== 1'b1) begin errors++; $display("FAIL exc%0d_valid got %b want 1", i, exc_valid); end
            checks++; if (exc_code !== code_t[i]) begin errors++; $display("FAIL exc%0d_code got %b want %b", i, exc_code, code_t[i]); end
            checks++; if (exc_badvaddr !== addr_t[i]) begin errors++; $display("FAIL exc%0d_badvaddr got %h want %h", i, exc_badvaddr, addr_t[i]); end
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL exc%0d_count got %0d want 0", i, count); end
            @(posedge clk); #1;
            checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL exc%0d_pulse got %b want 0", i, exc_valid); end
        end
        send(2'd2, 32'h0000_7F14, 32'hCAFE_F00D);
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL t1_noexc got %b want 0", exc_valid); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL t1_count got %0d want 1", count); end
        checks++; if (mem_byteen !== 4'b1111 || mem_addr !== 32'h0000_7F14)
            begin errors++; $display("FAIL t1_entry got %b/%h want 1111/00007f14", mem_byteen, mem_addr); end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t1_drain got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d[$];
        logic [31:0] exp_a[$];
        int mcount = 0;
        int id = 0;
        logic acc, pp;
        mem_ready = 1'b0;
        req_size  = 2'd2;
        for (int c = 0; c < 24; c++) begin
            if (c == 6) mem_ready = 1'b1;
            req_valid = (c < 16);
            req_addr  = 32'h0000_0100 + 32'(id) * 32'd4;
            req_wdata = 32'hA000_0000 + 32'(id);
            checks++; if (req_ready !== (mcount < 4)) begin errors++; $display("FAIL b2b_ready c=%0d got %b want %b", c, req_ready, (mcount < 4)); end
            acc = req_valid && (mcount < 4);
            pp  = mem_ready && (mcount > 0);
            @(posedge clk); #1;
            if (pp) begin void'(exp_d.pop_front()); void'(exp_a.pop_front()); end
            if (acc) begin exp_d.push_back(req_wdata); exp_a.push_back(req_addr); id++; end
            mcount = exp_d.size();
            checks++; if (count !== 3'(mcount)) begin errors++; $display("FAIL b2b_count c=%0d got %0d want %0d", c, count, mcount); end
            if (mcount > 0) begin
                checks++; if (mem_wdata !== exp_d[0] || mem_addr !== exp_a[0] || mem_byteen !== 4'b1111)
                    begin errors++; $display("FAIL b2b_head c=%0d got %h@%h want %h@%h", c, mem_wdata, mem_addr, exp_d[0], exp_a[0]); end
            end
            $display("cycle %0d push=%b pop=%b count=%0d head=%h", c, acc, pp, count, mem_wdata);
        end
        req_valid = 1'b0;
        checks++; if (empty !== 1'b1 || id != 13) begin errors++; $display("FAIL b2b_final got empty=%b pushes=%0d want 1/13", empty, id); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        send(2'd2, 32'h0000_0200, 32'h0000_0001);
        send(2'd2, 32'h0000_0204, 32'h0000_0002);
        send(2'd2, 32'h0000_0208, 32'h0000_0003);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
        mem_ready = 1'b1;
        #2; reset_n = 1'b0; #1;
        checks++; if (count !== 3'd0 || mem_valid !== 1'b0 || empty !== 1'b1)
            begin errors++; $display("FAIL mid_async got count=%0d valid=%b empty=%b want 0/0/1", count, mem_valid, empty); end
        checks++; if (exc_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_flags got exc=%b ready=%b want 0/0", exc_valid, req_ready); end
        @(posedge clk); #1;
        checks++; if (count !== 3'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_hold got count=%0d ready=%b want 0/0", count, req_ready); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", req_ready); end
        send(2'd2, 32'h0000_2000, 32'h55AA_55AA);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_wdata !== 32'h55AA_55AA)
            begin errors++; $display("FAIL post_rst_store got %b/%h/%h want 1/00002000/55aa55aa", mem_valid, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_rst_drain got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_exceptions();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
